// File: rtl/fp16_accum_sequencer.sv
// fp16_accum_sequencer
//   Folds a packetised stream of binary16 values into a running sum by
//   driving a sequential half-precision adder one operation per element.
//   The first element of a packet seeds the accumulator directly. Every
//   later element is added to it. One result is presented per packet.
//
// Ports
//   clk, rst_n              clock, synchronous active-low reset
//   in_valid/in_ready       element handshake; in_data value, in_last closes packet
//   add_start               start pulse to the adder (only while add_ready=1)
//   add_a, add_b            adder operands: running sum, new element
//   add_ready, add_sum      adder idle/result strobe and result
//   add_n/v/u/z             adder flags for add_sum
//   out_valid/out_ready     packet result handshake
//   out_sum, out_n/v/u/z    packet sum and flags (v/u sticky over the packet)
//   out_err                 an adder operation timed out within the packet
//   out_count               elements in the packet (saturating)

module fp16_accum_sequencer #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    input  logic             in_last,
    output logic             add_start,
    output logic [15:0]      add_a,
    output logic [15:0]      add_b,
    input  logic             add_ready,
    input  logic [15:0]      add_sum,
    input  logic             add_n,
    input  logic             add_v,
    input  logic             add_u,
    input  logic             add_z,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_sum,
    output logic             out_n,
    output logic             out_v,
    output logic             out_u,
    output logic             out_z,
    output logic             out_err,
    output logic [CNT_W-1:0] out_count
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [TMO_W-1:0] TMO_ONE  = {{(TMO_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_FIRST = 3'd0,
        ST_NEXT  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_BUSY  = 3'd3,
        ST_WAIT  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [15:0]        acc_r;
    logic [15:0]        opb_r;
    logic               last_r;
    logic [CNT_W-1:0]   count_r;
    logic               n_r;
    logic               z_r;
    logic               v_r;
    logic               u_r;
    logic               err_r;
    logic [TMO_W-1:0]   tmo_r;
    logic               in_ready_s;
    logic               add_start_s;
    logic               out_valid_s;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_FIRST;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_FIRST: begin
                if (in_valid) begin
                    if (in_last) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_NEXT;
                    end
                end else begin
                    state_nxt_s = ST_FIRST;
                end
            end
            ST_NEXT: begin
                if (in_valid) begin
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_NEXT;
                end
            end
            ST_ISSUE: begin
                if (add_ready) begin
                    state_nxt_s = ST_BUSY;
                end else begin
                    state_nxt_s = ST_ISSUE;
                end
            end
            // The adder only drops add_ready the cycle after start, so the
            // strobe is not trusted here.
            ST_BUSY: state_nxt_s = ST_WAIT;
            ST_WAIT: begin
                if (add_ready || (tmo_r == TMO_LAST)) begin
                    if (last_r) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_NEXT;
                    end
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_nxt_s = ST_FIRST;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: state_nxt_s = ST_FIRST;
        endcase
    end

    // State-decoded handshake outputs
    always_comb begin
        in_ready_s  = 1'b0;
        add_start_s = 1'b0;
        out_valid_s = 1'b0;
        case (state_r)
            ST_FIRST: in_ready_s  = 1'b1;
            ST_NEXT:  in_ready_s  = 1'b1;
            // Never start an adder that is not idle; this also covers the
            // adder still being busy after our own reset.
            ST_ISSUE: add_start_s = add_ready;
            ST_DONE:  out_valid_s = 1'b1;
            default:  out_valid_s = 1'b0;
        endcase
    end

    // Accumulator, flags, element counter and adder timeout counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_r   <= 16'h0000;
            opb_r   <= 16'h0000;
            last_r  <= 1'b0;
            count_r <= {CNT_W{1'b0}};
            n_r     <= 1'b0;
            z_r     <= 1'b0;
            v_r     <= 1'b0;
            u_r     <= 1'b0;
            err_r   <= 1'b0;
            tmo_r   <= {TMO_W{1'b0}};
        end else begin
            case (state_r)
                ST_FIRST: begin
                    if (in_valid) begin
                        acc_r   <= in_data;
                        count_r <= CNT_ONE;
                        // Sign/zero of the seed value stand until an add lands.
                        n_r     <= in_data[15];
                        z_r     <= (in_data[14:0] == 15'd0);
                    end
                end
                ST_NEXT: begin
                    if (in_valid) begin
                        opb_r  <= in_data;
                        last_r <= in_last;
                        if (!(&count_r)) begin
                            count_r <= count_r + CNT_ONE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (add_ready) begin
                        tmo_r <= {TMO_W{1'b0}};
                    end
                end
                ST_BUSY: begin
                    tmo_r <= tmo_r + TMO_ONE;
                end
                ST_WAIT: begin
                    if (add_ready) begin
                        acc_r <= add_sum;
                        n_r   <= add_n;
                        z_r   <= add_z;
                        v_r   <= v_r | add_v;
                        u_r   <= u_r | add_u;
                    end else if (tmo_r == TMO_LAST) begin
                        // Give up on this element; the sum keeps its old value.
                        err_r <= 1'b1;
                    end else begin
                        tmo_r <= tmo_r + TMO_ONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        v_r     <= 1'b0;
                        u_r     <= 1'b0;
                        err_r   <= 1'b0;
                        count_r <= {CNT_W{1'b0}};
                    end
                end
                default: begin
                    tmo_r <= {TMO_W{1'b0}};
                end
            endcase
        end
    end

    assign in_ready  = in_ready_s;
    assign add_start = add_start_s;
    assign add_a     = acc_r;
    assign add_b     = opb_r;
    assign out_valid = out_valid_s;
    assign out_sum   = acc_r;
    assign out_n     = n_r;
    assign out_v     = v_r;
    assign out_u     = u_r;
    assign out_z     = z_r;
    assign out_err   = err_r;
    assign out_count = count_r;

endmodule

// File: tb/tb_fp16_accum_sequencer.sv
// Bench for fp16_accum_sequencer: directed packets against a 3-stage adder
// model (table of hand-computed binary16 sums). Expected packet results are
// queued by the stimulus and checked by an independent output monitor.

module tb_fp16_accum_sequencer;

    localparam int CNT_W = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [15:0]       in_data;
    logic              in_last;
    logic              add_start;
    logic [15:0]       add_a;
    logic [15:0]       add_b;
    logic              add_ready;
    logic [15:0]       add_sum;
    logic              add_n, add_v, add_u, add_z;
    logic              out_valid;
    logic              out_ready;
    logic [15:0]       out_sum;
    logic              out_n, out_v, out_u, out_z, out_err;
    logic [CNT_W-1:0]  out_count;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    typedef struct packed {
        logic [15:0]      sum;
        logic             n;
        logic             v;
        logic             u;
        logic             z;
        logic             err;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t exp_e;
    exp_t act_e;
    int   pkt_idx = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    fp16_accum_sequencer #(.TIMEOUT(16), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .add_start(add_start), .add_a(add_a), .add_b(add_b),
        .add_ready(add_ready), .add_sum(add_sum),
        .add_n(add_n), .add_v(add_v), .add_u(add_u), .add_z(add_z),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_n(out_n), .out_v(out_v), .out_u(out_u), .out_z(out_z),
        .out_err(out_err), .out_count(out_count)
    );

    // ---------------- adder model: idle -> 3 busy cycles -> idle with result
    function automatic logic [16:0] fadd(input logic [15:0] a, input logic [15:0] b);
        logic [31:0] k;
        k = {a, b};
        case (k)
            32'h3C00_4000: return {1'b0, 16'h4200};  // 1 + 2
            32'h4200_3800: return {1'b0, 16'h4300};  // 3 + 0.5
            32'h3C00_BC00: return {1'b0, 16'h0000};  // 1 - 1
            32'h7BFF_7BFF: return {1'b1, 16'h7C00};  // max + max overflows
            32'h7C00_BC00: return {1'b0, 16'h7C00};  // inf - 1
            default:       return {1'b0, 16'h7E00};
        endcase
    endfunction

    int          busy_cnt = 0;
    logic        hang = 1'b0;
    logic [16:0] res_r = 17'd0;

    assign add_ready = (busy_cnt == 0);
    assign add_sum   = res_r[15:0];
    assign add_v     = res_r[16];
    assign add_n     = res_r[15];
    assign add_z     = (res_r[14:0] == 15'd0);
    assign add_u     = 1'b0;

    always @(posedge clk) begin
        if (add_start && add_ready) begin
            busy_cnt <= hang ? 30 : 3;
            res_r    <= fadd(add_a, add_b);
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end

    // ---------------- adder protocol monitor
    logic prev_start = 1'b0;
    int   start_cnt = 0;
    int   start_cyc = 0;

    always @(negedge clk) begin
        if (rst_n && add_start) begin
            start_cnt = start_cnt + 1;
            start_cyc = cyc;
            checks = checks + 1;
            if (!add_ready || prev_start) begin
                errors = errors + 1;
                $display("FAIL add_start protocol: start=1 with add_ready=%b prev_start=%b, want ready=1 prev=0",
                         add_ready, prev_start);
            end
        end
        prev_start = add_start;
    end

    // ---------------- result scoreboard monitor
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            checks = checks + 1;
            act_e = {out_sum, out_n, out_v, out_u, out_z, out_err, out_count};
            if (exp_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL result unexpected: got sum=%h cnt=%0d, want no result", out_sum, out_count);
            end else begin
                exp_e = exp_q.pop_front();
                if (act_e !== exp_e) begin
                    errors = errors + 1;
                    $display("FAIL result pkt%0d: got sum=%h n=%b v=%b u=%b z=%b err=%b cnt=%0d, want sum=%h n=%b v=%b u=%b z=%b err=%b cnt=%0d",
                             pkt_idx, act_e.sum, act_e.n, act_e.v, act_e.u, act_e.z, act_e.err, act_e.cnt,
                             exp_e.sum, exp_e.n, exp_e.v, exp_e.u, exp_e.z, exp_e.err, exp_e.cnt);
                end
            end
            pkt_idx = pkt_idx + 1;
        end
    end

    // ---------------- helpers
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] s, input logic n, input logic v, input logic z,
                                input logic e, input int c);
        exp_t r;
        r.sum = s; r.n = n; r.v = v; r.u = 1'b0; r.z = z; r.err = e; r.cnt = CNT_W'(c);
        return r;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the element transferred.
    task automatic send(input logic [15:0] d, input logic l);
        int n;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks = checks + 1;
        if (!in_ready) begin
            errors = errors + 1;
            $display("FAIL send %h: got in_ready=0 after 200 cycles, want 1", d);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Returns at the negedge where out_valid is seen.
    task automatic wait_out(input string name, input int bound);
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < bound) begin
            @(negedge clk);
            n++;
        end
        checks = checks + 1;
        if (!out_valid) begin
            errors = errors + 1;
            $display("FAIL %s: got out_valid=0 after %0d cycles, want 1", name, bound);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, want $finish");
        $fatal(1, "watchdog");
    end

    int s0;
    int n_w;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = 16'h0000; in_last = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset in_ready", in_ready, 1);
        chk("reset out_valid", out_valid, 0);
        chk("reset add_start", add_start, 0);
        chk("reset out_sum", out_sum, 0);
        chk("reset out_count", out_count, 0);
        chk("reset out_err", out_err, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // 1 + 2 + 0.5 = 3.5
        s0 = start_cnt;
        exp_q.push_back(mk(16'h4300, 1'b0, 1'b0, 1'b0, 1'b0, 3));
        send(16'h3C00, 1'b0); send(16'h4000, 1'b0); send(16'h3800, 1'b1);
        wait_out("t1 out", 100);
        chk("t1 starts", start_cnt - s0, 2);
        @(posedge clk); #1;

        // single element, no adder use
        s0 = start_cnt;
        exp_q.push_back(mk(16'hBC00, 1'b1, 1'b0, 1'b0, 1'b0, 1));
        send(16'hBC00, 1'b1);
        wait_out("t2 out", 100);
        chk("t2 starts", start_cnt - s0, 0);
        @(posedge clk); #1;

        // 1 - 1 = +0
        s0 = start_cnt;
        exp_q.push_back(mk(16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 2));
        send(16'h3C00, 1'b0); send(16'hBC00, 1'b1);
        wait_out("t3 out", 100);
        chk("t3 starts", start_cnt - s0, 1);
        @(posedge clk); #1;

        // overflow on the first add stays sticky past a clean second add
        s0 = start_cnt;
        exp_q.push_back(mk(16'h7C00, 1'b0, 1'b1, 1'b0, 1'b0, 3));
        send(16'h7BFF, 1'b0); send(16'h7BFF, 1'b0); send(16'hBC00, 1'b1);
        wait_out("t4 out", 100);
        chk("t4 starts", start_cnt - s0, 2);
        @(posedge clk); #1;

        // backpressure hold, then back-to-back packet
        out_ready = 1'b0;
        exp_q.push_back(mk(16'h4200, 1'b0, 1'b0, 1'b0, 1'b0, 2));
        send(16'h3C00, 1'b0); send(16'h4000, 1'b1);
        wait_out("t5 out", 100);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t5 hold out_valid", out_valid, 1);
            chk("t5 hold out_sum", out_sum, 32'h4200);
            chk("t5 hold in_ready", in_ready, 0);
        end
        @(posedge clk); #1;
        exp_q.push_back(mk(16'h4200, 1'b0, 1'b0, 1'b0, 1'b0, 1));
        out_ready = 1'b1;
        fork
            begin
                @(negedge clk);
                @(negedge clk);
                chk("t5 release in_ready", in_ready, 1);
                chk("t5 release out_valid", out_valid, 0);
            end
            send(16'h4200, 1'b1);
        join
        wait_out("t5b out", 100);
        @(posedge clk); #1;

        // adder never answers: timeout, sum keeps the seed
        hang = 1'b1;
        exp_q.push_back(mk(16'h3C00, 1'b0, 1'b0, 1'b0, 1'b1, 2));
        send(16'h3C00, 1'b0); send(16'h4000, 1'b1);
        wait_out("t6 out", 100);
        checks = checks + 1;
        if ((cyc - start_cyc) > 17 || (cyc - start_cyc) < 3) begin
            errors = errors + 1;
            $display("FAIL t6 timeout latency: got %0d cycles, want <=17", cyc - start_cyc);
        end
        @(posedge clk); #1;

        // reset while waiting on the adder
        send(16'h3C00, 1'b0); send(16'h4000, 1'b1);
        n_w = 0;
        @(negedge clk);
        while (!add_start && n_w < 100) begin
            @(negedge clk);
            n_w++;
        end
        chk("t7 start seen", add_start, 1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        hang = 1'b0;
        @(negedge clk);
        chk("t7 out_valid", out_valid, 0);
        chk("t7 in_ready", in_ready, 1);
        chk("t7 add_start", add_start, 0);
        @(posedge clk); #1;
        s0 = start_cnt;
        exp_q.push_back(mk(16'h4200, 1'b0, 1'b0, 1'b0, 1'b0, 2));
        send(16'h3C00, 1'b0); send(16'h4000, 1'b1);
        wait_out("t7 out", 200);
        chk("t7 starts", start_cnt - s0, 1);
        @(posedge clk); #1;

        chk("scoreboard drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
